// File: rtl/alu_div_pkg.sv
// Shared types and constants for the iterative RV64M divider.
package alu_div_pkg;
  localparam int DIV_ITER_D = 64;
  localparam int DIV_ITER_W = 32;

  typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} div_state_t;

  function automatic logic op_signed(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_rem(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction
endpackage

// File: rtl/alu_div_unit_sign_adj.sv
// Conditional two's-complement negate with optional low-half sign-extend.
module div_sign_adj #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] val,
  input  logic            neg,
  input  logic            sext,
  output logic [XLEN-1:0] res
);
  localparam int H = XLEN / 2;

  logic [XLEN-1:0] mag;

  assign mag = neg ? -val : val;
  assign res = sext ? {{H{mag[H-1]}}, mag[H-1:0]} : mag;
endmodule

// File: rtl/alu_div_unit.sv
// Restoring integer divider for DIV/DIVU/REM/REMU and W forms, one quotient bit per cycle.
// Build option: ALU_DIV_EARLY_OUT_EN lets divide-by-zero and signed overflow skip CALC.
module alu_div_unit
  import alu_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(DIV_ITER_D) + 1;

  div_state_t      state;
  div_op_t         op_q;
  logic            word_q, neg_q, neg_r, dz_q, ovf_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] a_q, quo_q, rem_q, div_q;

  // Operand decode and absolute values (lane 0 = dividend, lane 1 = divisor)
  div_op_t                    op_in;
  logic                       sgn_in, sa, sb, dz_in, ovf_in;
  logic [1:0][XLEN-1:0]       opnd, opnd_abs;
  logic [1:0]                 opnd_neg;

  assign op_in    = div_op_t'(op_i);
  assign sgn_in   = op_signed(op_in);
  assign sa       = word_i ? a_i[H-1] : a_i[XLEN-1];
  assign sb       = word_i ? b_i[H-1] : b_i[XLEN-1];
  assign opnd     = {b_i, a_i};
  assign opnd_neg = {sgn_in & sb, sgn_in & sa};
  assign dz_in    = word_i ? (b_i[H-1:0] == '0) : (b_i == '0);
  assign ovf_in   = sgn_in & (word_i
                    ? ((a_i[H-1:0] == {1'b1, {(H-1){1'b0}}}) && (&b_i[H-1:0]))
                    : ((a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i)));

  generate
    for (genvar i = 0; i < 2; i++) begin : g_abs
      div_sign_adj #(.XLEN(XLEN)) u_abs (
        .val (opnd[i]),
        .neg (opnd_neg[i]),
        .sext(1'b0),
        .res (opnd_abs[i])
      );
    end
  endgenerate

  // One restoring step; the partial remainder never reaches 2^XLEN, so the
  // borrow out of the XLEN+1 bit difference is the "does not fit" flag.
  logic [XLEN:0] shl, diff;
  logic          ge;

  assign shl  = {rem_q, quo_q[XLEN-1]};
  assign diff = shl - {1'b0, div_q};
  assign ge   = ~diff[XLEN];

  // Result fix-up
  logic [XLEN-1:0] quo_fix, rem_fix, a_ext, q_sel, r_sel, res_nxt;

  div_sign_adj #(.XLEN(XLEN)) u_fix_q (.val(quo_q), .neg(neg_q), .sext(word_q), .res(quo_fix));
  div_sign_adj #(.XLEN(XLEN)) u_fix_r (.val(rem_q), .neg(neg_r), .sext(word_q), .res(rem_fix));
  div_sign_adj #(.XLEN(XLEN)) u_fix_a (.val(a_q),   .neg(1'b0),  .sext(word_q), .res(a_ext));

  always_comb begin
    q_sel = quo_fix;
    r_sel = rem_fix;
    if (dz_q) begin
      q_sel = '1;
      r_sel = a_ext;
    end else if (ovf_q) begin
      q_sel = a_ext;
      r_sel = '0;
    end
    res_nxt = op_rem(op_q) ? r_sel : q_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= DIV;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      cnt      <= '0;
      a_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (state != IDLE && flush_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_i && !flush_i) begin
            op_q   <= op_in;
            word_q <= word_i;
            a_q    <= a_i;
            // W dividends sit in the top half so the shift always taps the MSB
            quo_q  <= word_i ? {opnd_abs[0][H-1:0], {H{1'b0}}} : opnd_abs[0];
            div_q  <= word_i ? {{H{1'b0}}, opnd_abs[1][H-1:0]} : opnd_abs[1];
            rem_q  <= '0;
            neg_q  <= sgn_in & (sa ^ sb);
            neg_r  <= sgn_in & sa;
            dz_q   <= dz_in;
            ovf_q  <= ovf_in;
            cnt    <= word_i ? CW'(DIV_ITER_W) : CW'(DIV_ITER_D);
            busy_o <= 1'b1;
`ifdef ALU_DIV_EARLY_OUT_EN
            state  <= (dz_in || ovf_in) ? FIX : CALC;
`else
            state  <= CALC;
`endif
          end
          CALC: begin
            rem_q <= ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ge};
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIX;
          end
          FIX: begin
            result_o <= res_nxt;
            done_o   <= 1'b1;
            state    <= DONE;
          end
          DONE: begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/alu_div_unit.md
Name: alu_div_unit

Overview:
- Iterative multi-cycle integer divider for the RV64M DIV/DIVU/REM/REMU and W variants.
- Sits directly downstream of the ALU B-operand select. Consumes operand A (rs1 path) and operand B (selected B-mux output) in parallel with the single-cycle ALU.
- Raises busy to stall the pipeline until the result is ready.
- Uses a restoring algorithm, one quotient bit per cycle.

Parameters:
- XLEN, 64, datapath width; W ops use the low XLEN/2 bits.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  request; sampled only in IDLE
- op_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- word_i  in  1  1 = W variant (32-bit operation, sign-extended result)
- a_i  in  XLEN  dividend (operand A)
- b_i  in  XLEN  divisor (B-mux output)
- flush_i  in  1  synchronous abort from pipeline redirect
- busy_o  out  1  high from the cycle after start acceptance until done
- done_o  out  1  one-cycle pulse; result_o valid in that cycle
- result_o  out  XLEN  quotient or remainder; held until the next accepted start

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - busy_o=0, done_o=0, result_o=0.
  - All internal registers 0.
  - Reset asserted mid-operation discards the operation; no done.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: start_i=1 latches op, word, operands, and the absolute values of the operands for signed ops. Iteration counter loads N (64, or 32 when word_i=1). Next state CALC. start_i while not IDLE is ignored.
  - CALC: one shift-subtract step per cycle. Counter decrements; at 1 the next state is FIX.
  - FIX:
    - Negate quotient if the operand signs differ (signed ops).
    - Negate remainder if the dividend is negative (signed ops).
    - Select quotient or remainder.
    - For W: sign-extend bit 31 to 64 bits.
    - Register result_o. Next state DONE.
  - DONE: done_o=1 for exactly this cycle. Next state IDLE; a new start is accepted in the following cycle.
- Latency: done_o occurs N+2 cycles after the start cycle (64-bit: 66, W: 34).
- W signed ops use a_i[31] and b_i[31] as the signs; bits 63:32 of the inputs are ignored.
- Special cases (result values are independent of the optional feature):
  - Divide by zero:
    - Quotient = all ones.
    - Remainder = dividend (W: sign-extended low 32 bits).
  - Signed overflow (most-negative / -1, per width):
    - Quotient = dividend.
    - Remainder = 0.
- flush_i=1 in any non-IDLE state:
  - Next state IDLE; busy_o drops the following cycle.
  - No done_o; result_o unchanged.
  - flush_i has priority over the DONE pulse.
  - flush_i in IDLE blocks acceptance of a same-cycle start.

Optional Feature:
- Macro: ALU_DIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow cases skip CALC (IDLE -> FIX -> DONE), so done_o occurs 2 cycles after start.
- Not defined: these cases run the full N iterations, with identical result values and normal latency.

Decomposition:
- Shared package alu_div_pkg holds:
  - typedef enum div_op_t {DIV, DIVU, REM, REMU}
  - typedef enum div_state_t {IDLE, CALC, FIX, DONE}
  - constants DIV_ITER_D=64 and DIV_ITER_W=32
- One sub-module: div_sign_adj, a combinational conditional negate with an optional 32-to-64 sign-extend, instanced for operand absolute value and for result fix-up.

Test Plan:
- DIVU a=100, b=7 -> result_o=14, done_o 66 cycles after start. REMU same operands -> 2.
- DIV a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF. REMU -> 5. Latency 66 without the macro, 2 with ALU_DIV_EARLY_OUT_EN.
- DIV a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000. REM -> 0.
- DIVW a=0x0000_0000_FFFF_FFF8, b=3 -> 0xFFFF_FFFF_FFFF_FFFE, done at 34. REMW -> 0xFFFF_FFFF_FFFF_FFFE.
- Control:
  - Start, then flush_i at cycle 10 -> no done_o, busy_o=0 next cycle, result_o unchanged.
  - start_i pulsed while busy -> ignored.
  - rst_n low at cycle 20 -> all outputs 0 immediately.
